// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) between the master block and the slave memory.
// Latency: none, wires only.
// Backpressure: carried by the VALID/READY pairs of each channel.
interface axi_lite_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory: word-addressed register array with decode errors (SLVERR).
// Latency: write response / read data valid one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read; responses held until accepted.
module axi_lite_slave_mem #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi_lite_slave_mem_if.slave  bus
);
    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic { W_COLLECT, W_RESP } w_state_t;
    typedef enum logic { R_IDLE,    R_RESP } r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;

    r_state_t          r_state;
    logic              arready_q, rvalid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0] wr_addr, wr_off, rd_off;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ok, rd_ok;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign aw_hs = bus.AWVALID && awready_q;
    assign w_hs  = bus.WVALID  && wready_q;
    assign ar_hs = bus.ARVALID && arready_q;

    // A held address/data beat takes precedence over the live bus value.
    assign wr_addr = aw_held ? aw_addr_q : bus.AWADDR;
    assign wr_data = w_held  ? w_data_q  : bus.WDATA;

    // Offsets wrap modulo 2^ADDR_W; the explicit >= BASE_ADDR test stops low addresses aliasing.
    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_ok  = (wr_addr >= BASE_ADDR) && (wr_off[1:0] == 2'b00)
                    && ((wr_off >> 2) < ADDR_W'(DEPTH));
    assign wr_idx = wr_off[IDX_W+1:2];

    assign rd_off = bus.ARADDR - BASE_ADDR;
    assign rd_ok  = (bus.ARADDR >= BASE_ADDR) && (rd_off[1:0] == 2'b00)
                    && ((rd_off >> 2) < ADDR_W'(DEPTH));
    assign rd_idx = rd_off[IDX_W+1:2];

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = rdata_q;

    // Write path: collect AW and W in either order, commit to memory, hold B until accepted.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state   <= W_COLLECT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        if (wr_ok) begin
                            mem[wr_idx] <= wr_data;
                            bresp_q     <= OKAY;
                        end else begin
                            bresp_q     <= SLVERR;
                        end
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        w_state   <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= bus.AWADDR;
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= bus.WDATA;
                        end
                        // Also brings READYs up on the first cycle out of reset.
                        awready_q <= !(aw_held || aw_hs);
                        wready_q  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_COLLECT;
                    end
                end
            endcase
        end
    end

    // Read path: capture the addressed word (pre-write value on a same-edge commit), hold R until accepted.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_ok ? mem[rd_idx] : '0;
                        rresp_q   <= rd_ok ? OKAY : SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (bus.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem: directed table, corner sequences, random traffic vs. a word-array model.
// Latency checked: B/R valid exactly one cycle after the completing handshake.
// Backpressure checked: responses held stable and READYs low while BREADY/RREADY are withheld.
module tb_axi_lite_slave_mem;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_lite_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_lite_slave_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake did not complete within the cycle budget", name);
    endtask

    // Reference decode: in range, word aligned, above the base.
    function automatic bit model_ok(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off % 4 == 0) && (off / 4 < DEPTH);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        resp = 2'bxx;
        bus.AWADDR = addr;
        bus.WDATA  = data;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.AWVALID = !aw_done && (cyc >= aw_dly);
            bus.WVALID  = !w_done  && (cyc >= w_dly);
            @(negedge ACLK);
            check("bvalid_early", bus.BVALID, 0);
            if (w_done && !aw_done) check("wready_low_while_w_held", bus.WREADY, 0);
            if (aw_done && !w_done) check("awready_low_while_aw_held", bus.AWREADY, 0);
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout("write_accept");
            return;
        end
        check("bvalid_latency", bus.BVALID, 1);
        resp = bus.BRESP;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge ACLK); #1;
            check("b_hold_stable", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, resp, 2'b00});
        end
        bus.BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
        check("bvalid_clear", bus.BVALID, 0);
        check("aw_w_ready_reassert", {bus.AWREADY, bus.WREADY}, 2'b11);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit fire = 0;
        int cyc = 0;
        data = 'x;
        resp = 2'bxx;
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        while (!fire && cyc < 40) begin
            @(negedge ACLK);
            fire = bus.ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.ARVALID = 1'b0;
        if (!fire) begin
            timeout("read_accept");
            return;
        end
        check("rvalid_latency", bus.RVALID, 1);
        data = bus.RDATA;
        resp = bus.RRESP;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge ACLK); #1;
            check("r_hold_stable", {bus.RVALID, bus.RRESP, bus.RDATA, bus.ARREADY}, {1'b1, resp, data, 1'b0});
        end
        bus.RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.RREADY = 1'b0;
        check("rvalid_clear", bus.RVALID, 0);
        check("arready_reassert", bus.ARREADY, 1);
    endtask

    function automatic logic [40:0] all_outs();
        return {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                bus.BRESP, bus.RRESP, bus.RDATA};
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw_dly;
        int          w_dly;
        int          rdy_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs [12];
        logic [1:0]  resp;
        logic [31:0] rdata, old;

        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WVALID = 0; bus.BREADY = 0;
        bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset held for 4 clocks: every output low.
        @(posedge ACLK);
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            check("reset_outputs", all_outs(), 41'h0);
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("ready_low_first_cycle", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        check("ready_high_after_release", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        vecs[0]  = '{1, 32'h8,        32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h0};
        vecs[1]  = '{0, 32'h8,        32'h0,        0, 0, 0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1, 32'hC,        32'h12345678, 3, 0, 0, 2'b00, 32'h0};
        vecs[3]  = '{0, 32'hC,        32'h0,        0, 0, 1, 2'b00, 32'h12345678};
        vecs[4]  = '{1, 32'h40,       32'h11111111, 0, 0, 0, 2'b10, 32'h0};
        vecs[5]  = '{0, 32'h2,        32'h0,        0, 0, 0, 2'b10, 32'h0};
        vecs[6]  = '{0, 32'h0,        32'h0,        0, 0, 0, 2'b00, 32'h0};
        vecs[7]  = '{1, 32'h3C,       32'hCAFEF00D, 0, 2, 5, 2'b00, 32'h0};
        vecs[8]  = '{0, 32'h3C,       32'h0,        0, 0, 5, 2'b00, 32'hCAFEF00D};
        vecs[9]  = '{1, 32'hFFFFFFFC, 32'h55AA55AA, 1, 1, 0, 2'b10, 32'h0};
        vecs[10] = '{0, 32'hFFFFFFFC, 32'h0,        0, 0, 0, 2'b10, 32'h0};
        vecs[11] = '{0, 32'h3E,       32'h0,        0, 0, 2, 2'b10, 32'h0};

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].rdy_dly, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                if (model_ok(vecs[i].addr)) ref_mem[model_idx(vecs[i].addr)] = vecs[i].data;
            end else begin
                do_read(vecs[i].addr, vecs[i].rdy_dly, rdata, resp);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end

        // Write commit and read capture on the same edge, same word: read sees the old value.
        old = ref_mem[1];
        bus.AWADDR = 32'h4; bus.WDATA = 32'hA5A5A5A5; bus.ARADDR = 32'h4;
        bus.AWVALID = 1; bus.WVALID = 1; bus.ARVALID = 1;
        @(negedge ACLK);
        check("same_edge_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        check("same_edge_valids", {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}, 6'b110000);
        check("same_edge_old_data", bus.RDATA, old);
        bus.BREADY = 1; bus.RREADY = 1;
        @(posedge ACLK); #1;
        bus.BREADY = 0; bus.RREADY = 0;
        check("same_edge_both_clear", {bus.BVALID, bus.RVALID}, 2'b00);
        ref_mem[1] = 32'hA5A5A5A5;
        do_read(32'h4, 0, rdata, resp);
        check("same_edge_new_data", rdata, 32'hA5A5A5A5);

        // Random traffic against the word-array model.
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a, d;
            bit          ok;
            a  = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH - 1)) * 4;
            d  = 32'($urandom);
            ok = model_ok(a);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
                check("rand_bresp", resp, ok ? 2'b00 : 2'b10);
                if (ok) ref_mem[model_idx(a)] = d;
            end else begin
                do_read(a, $urandom_range(0, 2), rdata, resp);
                check("rand_rresp", resp, ok ? 2'b00 : 2'b10);
                check("rand_rdata", rdata, ok ? ref_mem[model_idx(a)] : 32'h0);
            end
        end

        // Reset mid-transaction: a captured W beat must be discarded and memory cleared.
        do_write(32'h8, 32'h0BADF00D, 0, 0, 0, resp);
        bus.WDATA = 32'h77777777;
        bus.WVALID = 1;
        @(negedge ACLK);
        check("pre_reset_wready", bus.WREADY, 1);
        @(posedge ACLK); #1;
        bus.WVALID = 0;
        ARESETn = 0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        check("mid_reset_outputs", all_outs(), 41'h0);
        ARESETn = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge ACLK); #1;
        do_write(32'h10, 32'h24681357, 0, 4, 0, resp);
        check("post_reset_bresp", resp, 2'b00);
        ref_mem[4] = 32'h24681357;
        do_read(32'h8, 0, rdata, resp);
        check("post_reset_mem_cleared", rdata, 32'h0);
        do_read(32'h10, 0, rdata, resp);
        check("post_reset_write", rdata, ref_mem[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
